// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: control encodings and the
// decoded control bundle that travels down the pipe.
package core_pkg;

  // Write-back data source select
  typedef enum logic [1:0] {
    WDSEL_ALU = 2'b00,
    WDSEL_MEM = 2'b01,
    WDSEL_PC  = 2'b10
  } wdsel_e;

  // Next-PC operation
  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b100
  } npcop_e;

  // ALU operation encodings
  typedef enum logic [4:0] {
    ALUOP_NOP   = 5'b00000,
    ALUOP_LUI   = 5'b00001,
    ALUOP_AUIPC = 5'b00010,
    ALUOP_ADD   = 5'b00011,
    ALUOP_SUB   = 5'b00100,
    ALUOP_XOR   = 5'b00101,
    ALUOP_OR    = 5'b00110,
    ALUOP_AND   = 5'b00111,
    ALUOP_SLL   = 5'b01000,
    ALUOP_SRL   = 5'b01001,
    ALUOP_SRA   = 5'b01010,
    ALUOP_SLT   = 5'b01011,
    ALUOP_SLTU  = 5'b01100,
    ALUOP_BEQ   = 5'b01101,
    ALUOP_BNE   = 5'b01110,
    ALUOP_BLT   = 5'b01111,
    ALUOP_BGE   = 5'b10000,
    ALUOP_BLTU  = 5'b10001,
    ALUOP_BGEU  = 5'b10010
  } aluop_e;

  // Decoded control bundle carried from ID into EX
  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic [4:0] aluop;
    logic [2:0] npcop;
    logic [1:0] wdsel;
    logic [2:0] dmtype;
  } ctrl_t;

  // A bubble has every control inactive: no write, no store, PC+4, ALU data
  localparam ctrl_t CTRL_BUBBLE = '0;

  // True when the write-data select marks the instruction as a load
  function automatic logic is_load(input logic [1:0] wdsel);
    return wdsel == WDSEL_MEM;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose
// destination is a source of the real instruction currently in ID.
module load_use_detect
  import core_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic [1:0] ex_wdsel_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  // rs2 is compared for every format; a spurious stall is harmless
  always_comb begin
    hazard_o = ex_valid_i && is_load(ex_wdsel_i) && (ex_rd_i != 5'd0) &&
               id_valid_i && ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble
// insertion, flush/hold handling and a saturating bubble counter.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_RegWrite,
  input  logic            id_MemWrite,
  input  logic            id_ALUSrc,
  input  logic [4:0]      id_ALUOp,
  input  logic [2:0]      id_NPCOp,
  input  logic [1:0]      id_WDSel,
  input  logic [2:0]      id_DMType,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_RegWrite,
  output logic            ex_MemWrite,
  output logic            ex_ALUSrc,
  output logic [4:0]      ex_ALUOp,
  output logic [2:0]      ex_NPCOp,
  output logic [1:0]      ex_WDSel,
  output logic [2:0]      ex_DMType,
  output logic            load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hazard;
  ctrl_t            id_ctrl;
  logic [4:0]       rs_idx   [2];
  logic [XLEN-1:0]  rs_rdata [2];
  logic [XLEN-1:0]  rs_fwd   [2];

  assign id_ctrl = '{regwrite: id_RegWrite, memwrite: id_MemWrite,
                     alusrc: id_ALUSrc, aluop: id_ALUOp, npcop: id_NPCOp,
                     wdsel: id_WDSel, dmtype: id_DMType};

  assign rs_idx[0]   = id_rs1;
  assign rs_idx[1]   = id_rs2;
  assign rs_rdata[0] = id_rs1_data;
  assign rs_rdata[1] = id_rs2_data;

  // Write-back bypass: the register file is read before WB writes it, so
  // a same-cycle write to a source register is forwarded here (never x0)
  for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
    assign rs_fwd[gi] = (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rs_idx[gi]))
                        ? wb_data : rs_rdata[gi];
  end

  load_use_detect u_detect (
    .ex_valid_i (valid_q),
    .ex_wdsel_i (ctrl_q.wdsel),
    .ex_rd_i    (rd_q),
    .id_valid_i (id_valid),
    .id_rs1_i   (id_rs1),
    .id_rs2_i   (id_rs2),
    .hazard_o   (hazard)
  );

  // A flush or hold this cycle means ID will not be re-presented as-is,
  // so the front end only freezes for a genuine load-use bubble
  assign load_use_stall = hazard & ~ex_flush & ~ex_hold;

  // Next-state selection: hold > flush > load-use bubble > capture
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (!ex_hold) begin
      if (ex_flush || hazard) begin
        // Data fields are left as they were; only the controls are killed
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
        if (!ex_flush && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        valid_d    = id_valid;
        ctrl_d     = id_valid ? id_ctrl : CTRL_BUBBLE;
        pc_d       = id_pc;
        rs1_data_d = rs_fwd[0];
        rs2_data_d = rs_fwd[1];
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
      end
    end
  end

  // Pipeline state; reset empties EX and clears the bubble count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_BUBBLE;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_RegWrite = ctrl_q.regwrite;
  assign ex_MemWrite = ctrl_q.memwrite;
  assign ex_ALUSrc   = ctrl_q.alusrc;
  assign ex_ALUOp    = ctrl_q.aluop;
  assign ex_NPCOp    = ctrl_q.npcop;
  assign ex_WDSel    = ctrl_q.wdsel;
  assign ex_DMType   = ctrl_q.dmtype;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// hazard/saturation sequences, and a randomized run against a reference model.
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_RegWrite, id_MemWrite, id_ALUSrc;
  logic [4:0]      id_ALUOp;
  logic [2:0]      id_NPCOp;
  logic [1:0]      id_WDSel;
  logic [2:0]      id_DMType;
  logic            wb_RegWrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_flush, ex_hold;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            ex_RegWrite, ex_MemWrite, ex_ALUSrc;
  logic [4:0]      ex_ALUOp;
  logic [2:0]      ex_NPCOp;
  logic [1:0]      ex_WDSel;
  logic [2:0]      ex_DMType;
  logic            load_use_stall;
  logic [CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
    .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel), .id_DMType(id_DMType),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
    .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model: what EX should hold ----------------
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite, memwrite, alusrc;
    logic [4:0]  aluop;
    logic [2:0]  npcop;
    logic [1:0]  wdsel;
    logic [2:0]  dmtype;
    int          cnt;
  } ex_t;

  ex_t m;

  task automatic model_reset();
    m.valid = 0; m.pc = 0; m.rs1d = 0; m.rs2d = 0; m.imm = 0;
    m.rs1 = 0; m.rs2 = 0; m.rd = 0;
    m.regwrite = 0; m.memwrite = 0; m.alusrc = 0; m.aluop = 0;
    m.npcop = 0; m.wdsel = 0; m.dmtype = 0; m.cnt = 0;
  endtask

  // Register value the EX stage should see: the freshest write wins
  function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] rf_val);
    if (wb_RegWrite && wb_rd != 0 && wb_rd == idx) return wb_data;
    return rf_val;
  endfunction

  // A load in EX whose result a real ID instruction needs
  function automatic logic model_hazard();
    return m.valid && (m.wdsel == 2'b01) && (m.rd != 0) && id_valid &&
           ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  task automatic model_edge();
    if (ex_hold) return;
    if (ex_flush || model_hazard()) begin
      if (!ex_flush && m.cnt < CNT_MAX) m.cnt = m.cnt + 1;
      m.valid = 0; m.regwrite = 0; m.memwrite = 0; m.npcop = 0; m.wdsel = 0;
      return;
    end
    m.valid = id_valid;
    m.pc = id_pc; m.imm = id_imm;
    m.rs1d = reg_value(id_rs1, id_rs1_data);
    m.rs2d = reg_value(id_rs2, id_rs2_data);
    m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
    if (id_valid) begin
      m.regwrite = id_RegWrite; m.memwrite = id_MemWrite; m.alusrc = id_ALUSrc;
      m.aluop = id_ALUOp; m.npcop = id_NPCOp; m.wdsel = id_WDSel; m.dmtype = id_DMType;
    end else begin
      m.regwrite = 0; m.memwrite = 0; m.npcop = 0; m.wdsel = 0;
    end
  endtask

  // ---------------- comparisons ----------------
  task automatic check_out(input string name);
    logic [15:0] got_c, exp_c, mask;
    logic ok;
    got_c = {ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType};
    exp_c = {m.regwrite, m.memwrite, m.alusrc, m.aluop, m.npcop, m.wdsel, m.dmtype};
    // ALUSrc/ALUOp/DMType of a bubble are unconstrained
    mask  = m.valid ? 16'hFFFF : 16'b1100_0000_1111_1000;
    n_vec++;
    ok = (ex_valid === m.valid) && ((got_c & mask) === (exp_c & mask)) &&
         (ex_pc === m.pc) && (ex_rs1_data === m.rs1d) && (ex_rs2_data === m.rs2d) &&
         (ex_imm === m.imm) && (ex_rs1 === m.rs1) && (ex_rs2 === m.rs2) &&
         (ex_rd === m.rd) && (bubble_cnt === CNT_W'(m.cnt));
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got v=%0b ctl=%h pc=%h r1=%h r2=%h imm=%h idx=%0d/%0d/%0d cnt=%0d, expected v=%0b ctl=%h pc=%h r1=%h r2=%h imm=%h idx=%0d/%0d/%0d cnt=%0d (ctl mask %h)",
               name, ex_valid, got_c, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, bubble_cnt,
               m.valid, exp_c, m.pc, m.rs1d, m.rs2d, m.imm, m.rs1, m.rs2, m.rd, m.cnt, mask);
    end
  endtask

  task automatic check_reset(input string name);
    n_vec++;
    if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
         ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType,
         load_use_stall, bubble_cnt} !== '0) begin
      n_err++;
      $display("FAIL %s: got v=%0b pc=%h r1=%h r2=%h imm=%h rd=%0d ctl=%b/%b/%b/%h/%h/%h/%h stall=%0b cnt=%0d, expected all zero",
               name, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_RegWrite, ex_MemWrite,
               ex_ALUSrc, ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType, load_use_stall, bubble_cnt);
    end
  endtask

  // One clock: inputs are already driven; check stall mid-cycle, then outputs after the edge
  task automatic cycle(input string name, output logic got_stall);
    logic exp_stall;
    @(negedge clk);
    exp_stall = model_hazard() && !ex_flush && !ex_hold;
    got_stall = load_use_stall;
    n_vec++;
    if (got_stall !== exp_stall) begin
      n_err++;
      $display("FAIL %s/stall: got %0b, expected %0b", name, got_stall, exp_stall);
    end
    model_edge();
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [1:0] wd, input logic rw, input logic [4:0] aop,
                       input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic fl, input logic hd);
    id_valid = v; id_pc = pc; id_rs1_data = r1d; id_rs2_data = pc ^ 32'h5A5A_0000;
    id_imm = pc + 32'h1000; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_RegWrite = rw; id_MemWrite = 1'b0; id_ALUSrc = (wd == 2'b01);
    id_ALUOp = aop; id_NPCOp = 3'b000; id_WDSel = wd;
    id_DMType = (wd == 2'b01) ? 3'b010 : 3'b000;
    wb_RegWrite = wbw; wb_rd = wbrd; wb_data = wbd;
    ex_flush = fl; ex_hold = hd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v; logic [31:0] pc, r1d; logic [4:0] rs1, rs2, rd; logic [1:0] wd; logic rw; logic [4:0] aop;
    logic wbw; logic [4:0] wbrd; logic [31:0] wbd; logic fl, hd;
    logic e_stall, e_valid; logic [31:0] e_pc, e_r1d; int e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  task automatic run_pair(input string name);
    logic s;
    drive(1, 32'h400, 32'h1, 5'd0, 5'd0, 5'd5, 2'b01, 1, 5'b00011, 0, 0, 0, 0, 0);
    cycle({name, "/load"}, s);
    drive(1, 32'h404, 32'h2, 5'd5, 5'd0, 5'd6, 2'b00, 1, 5'b00011, 0, 0, 0, 0, 0);
    cycle({name, "/use"}, s);
    cycle({name, "/use2"}, s);
    $display("%s: bubble_cnt=%0d", name, bubble_cnt);
  endtask

  initial begin
    logic s;

    //           v pc        r1d          rs1 rs2 rd  wd    rw aop       wbw wbrd wbd           fl hd  stall v pc        r1d          cnt
    vt[0]  = '{1, 32'h100, 32'h11,       1,  2,  3,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h100, 32'h11,       0};
    vt[1]  = '{1, 32'h104, 32'h22,       0,  0,  5,  2'b01, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h104, 32'h22,       0};
    vt[2]  = '{1, 32'h108, 32'h33,       6,  5,  8,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  1, 0, 32'h104, 32'h22,       1};
    vt[3]  = '{1, 32'h108, 32'h33,       6,  5,  8,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h108, 32'h33,       1};
    vt[4]  = '{1, 32'h10C, 32'h40,       0,  0,  0,  2'b01, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h10C, 32'h40,       1};
    vt[5]  = '{1, 32'h110, 32'h44,       0,  0,  9,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h110, 32'h44,       1};
    vt[6]  = '{1, 32'h114, 32'h0,        7,  0,  10, 2'b00, 1, 5'b00011, 1, 7, 32'hDEADBEEF,  0, 0,  0, 1, 32'h114, 32'hDEADBEEF, 1};
    vt[7]  = '{1, 32'h118, 32'h0,        0,  0,  11, 2'b00, 1, 5'b00011, 1, 0, 32'hDEADBEEF,  0, 0,  0, 1, 32'h118, 32'h0,        1};
    vt[8]  = '{1, 32'h11C, 32'h77,       0,  0,  12, 2'b01, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h11C, 32'h77,       1};
    vt[9]  = '{1, 32'h120, 32'h88,       12, 0,  14, 2'b00, 1, 5'b00011, 0, 0, 32'h0,         1, 0,  0, 0, 32'h11C, 32'h77,       1};
    vt[10] = '{1, 32'h124, 32'h55,       1,  2,  13, 2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h124, 32'h55,       1};
    vt[11] = '{1, 32'h200, 32'h99,       13, 13, 15, 2'b01, 1, 5'b00100, 0, 0, 32'h0,         0, 1,  0, 1, 32'h124, 32'h55,       1};
    vt[12] = '{1, 32'h204, 32'h9A,       3,  4,  16, 2'b00, 0, 5'b00101, 1, 3, 32'h1234,      1, 1,  0, 1, 32'h124, 32'h55,       1};
    vt[13] = '{0, 32'h208, 32'h9B,       5,  6,  17, 2'b10, 1, 5'b00110, 0, 0, 32'h0,         0, 1,  0, 1, 32'h124, 32'h55,       1};
    vt[14] = '{0, 32'h300, 32'h66,       1,  1,  1,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 0, 32'h300, 32'h66,       1};
    vt[15] = '{1, 32'h304, 32'h10,       0,  0,  5,  2'b01, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h304, 32'h10,       1};
    vt[16] = '{1, 32'h308, 32'h20,       5,  0,  6,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 1,  0, 1, 32'h304, 32'h10,       1};
    vt[17] = '{1, 32'h308, 32'h20,       5,  0,  6,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  1, 0, 32'h304, 32'h10,       2};
    vt[18] = '{1, 32'h308, 32'h20,       5,  0,  6,  2'b00, 1, 5'b00011, 0, 0, 32'h0,         0, 0,  0, 1, 32'h308, 32'h20,       2};

    // Reset with busy inputs: EX must come up empty
    drive(1, 32'hFFFF_FFF0, 32'hABCD, 5'd3, 5'd4, 5'd5, 2'b01, 1, 5'b00111, 1, 5'd3, 32'h99, 0, 0);
    model_reset();
    #1 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset("reset");
    $display("reset: ex_valid=%0b bubble_cnt=%0d stall=%0b", ex_valid, bubble_cnt, load_use_stall);

    // Directed table; reset is released together with the first vector
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].pc, vt[i].r1d, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].wd, vt[i].rw,
            vt[i].aop, vt[i].wbw, vt[i].wbrd, vt[i].wbd, vt[i].fl, vt[i].hd);
      rstn = 1'b1;
      cycle($sformatf("vec%0d", i), s);
      n_vec++;
      if (s !== vt[i].e_stall || ex_valid !== vt[i].e_valid || ex_pc !== vt[i].e_pc ||
          ex_rs1_data !== vt[i].e_r1d || bubble_cnt !== CNT_W'(vt[i].e_cnt)) begin
        n_err++;
        $display("FAIL vec%0d: got stall=%0b v=%0b pc=%h r1=%h cnt=%0d, expected stall=%0b v=%0b pc=%h r1=%h cnt=%0d",
                 i, s, ex_valid, ex_pc, ex_rs1_data, bubble_cnt,
                 vt[i].e_stall, vt[i].e_valid, vt[i].e_pc, vt[i].e_r1d, vt[i].e_cnt);
      end
      $display("vec%0d: stall=%0b ex_valid=%0b ex_pc=%h ex_rs1_data=%h bubble_cnt=%0d",
               i, s, ex_valid, ex_pc, ex_rs1_data, bubble_cnt);
    end

    // Chain of loads feeding each other: one bubble per dependent load
    drive(1, 32'h500, 32'h1, 5'd0, 5'd0, 5'd5, 2'b01, 1, 5'b00011, 0, 0, 0, 0, 0);
    cycle("chain/load1", s);
    drive(1, 32'h504, 32'h2, 5'd5, 5'd0, 5'd6, 2'b01, 1, 5'b00011, 0, 0, 0, 0, 0);
    cycle("chain/load2", s);
    cycle("chain/load2b", s);
    drive(1, 32'h508, 32'h3, 5'd6, 5'd0, 5'd7, 2'b00, 1, 5'b00011, 0, 0, 0, 0, 0);
    cycle("chain/use", s);
    cycle("chain/useb", s);
    n_vec++;
    if (bubble_cnt !== CNT_W'(4) || ex_pc !== 32'h508 || ex_valid !== 1'b1) begin
      n_err++;
      $display("FAIL chain: got cnt=%0d pc=%h v=%0b, expected cnt=4 pc=00000508 v=1", bubble_cnt, ex_pc, ex_valid);
    end
    $display("chain: bubble_cnt=%0d ex_pc=%h", bubble_cnt, ex_pc);

    // Saturation: 4 -> 15 after eleven pairs, twelfth and thirteenth stay at 15
    for (int k = 0; k < 13; k++) run_pair($sformatf("sat%0d", k));
    n_vec++;
    if (bubble_cnt !== CNT_W'(CNT_MAX)) begin
      n_err++;
      $display("FAIL saturate: got cnt=%0d, expected %0d", bubble_cnt, CNT_MAX);
    end

    // Randomized run with one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rstn = 1'b0;
        #1;
        check_reset("mid_reset");
        model_reset();
        #1 rstn = 1'b1;
      end
      id_valid    = ($urandom_range(0, 9) != 0);
      id_pc       = $urandom;
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      id_RegWrite = 1'($urandom_range(0, 1));
      id_MemWrite = 1'($urandom_range(0, 1));
      id_ALUSrc   = 1'($urandom_range(0, 1));
      id_ALUOp    = 5'($urandom_range(0, 31));
      id_NPCOp    = 3'($urandom_range(0, 7));
      id_WDSel    = 2'($urandom_range(0, 3));
      id_DMType   = 3'($urandom_range(0, 7));
      wb_RegWrite = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      ex_flush    = ($urandom_range(0, 9) == 0);
      ex_hold     = ($urandom_range(0, 9) == 0);
      cycle($sformatf("rnd%0d", i), s);
      $display("rnd%0d: stall=%0b ex_valid=%0b ex_pc=%h bubble_cnt=%0d", i, s, ex_valid, ex_pc, bubble_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
